// File: rtl/pattern_authenticator.sv
// pattern_authenticator: checks a sequence of directional-button presses
// (T/D/L/R) against a stored password. A correct entry holds "unlocked" for
// UNLOCK_CYCLES cycles. Each wrong entry pulses "error" for one cycle and
// counts as a failure. MAX_FAIL consecutive failures hold "locked" for
// LOCK_CYCLES cycles.
// Optional feature macro: PWD_PROG_EN. It adds a PROGRAM state, entered
// from UNLOCKED, that writes a new password.
module pattern_authenticator #(
    parameter int                  SEQ_LEN       = 4,
    parameter logic [2*SEQ_LEN-1:0] PASSWORD     = 8'hE8,
    parameter int                  MAX_FAIL      = 3,
    parameter int                  UNLOCK_CYCLES = 16,
    parameter int                  LOCK_CYCLES   = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             T,
    input  logic                             D,
    input  logic                             L,
    input  logic                             R,
    input  logic                             prog,
    output logic                             unlocked,
    output logic                             error,
    output logic                             locked,
    output logic [$clog2(SEQ_LEN+1)-1:0]     entry_cnt,
    output logic [$clog2(MAX_FAIL+1)-1:0]    fail_cnt,
    output logic                             prog_busy
);

    localparam int EW   = $clog2(SEQ_LEN + 1);
    localparam int FW   = $clog2(MAX_FAIL + 1);
    localparam int TMAX = (UNLOCK_CYCLES > LOCK_CYCLES) ? UNLOCK_CYCLES : LOCK_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [EW-1:0] LAST_IDX   = EW'(SEQ_LEN - 1);
    localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAIL);
    localparam logic [TW-1:0] T_UNLOCK   = TW'(UNLOCK_CYCLES);
    localparam logic [TW-1:0] T_LOCK     = TW'(LOCK_CYCLES);
    localparam logic [TW-1:0] T_ONE      = TW'(1);

    typedef enum logic [2:0] {
        ST_ENTRY    = 3'd0,
        ST_UNLOCKED = 3'd1,
        ST_FAIL     = 3'd2,
        ST_LOCKOUT  = 3'd3,
        ST_PROGRAM  = 3'd4
    } state_t;

    // Read password slot idx (symbol i lives at bits [2i+1:2i]).
    function automatic logic [1:0] get_slot(input logic [2*SEQ_LEN-1:0] pw,
                                            input logic [EW-1:0] idx);
        logic [1:0] r;
        r = 2'b00;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (idx == EW'(i)) r = pw[2*i +: 2];
        end
        return r;
    endfunction

    // Decode rising edges {R,L,D,T} into {valid, code}; several at once is invalid.
    function automatic logic [2:0] decode_sym(input logic [3:0] rise);
        logic [2:0] r;
        case (rise)
            4'b0001: r = 3'b100;
            4'b0010: r = 3'b101;
            4'b0100: r = 3'b110;
            4'b1000: r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    state_t            state_r, state_s;
    logic [3:0]        hist_r;
    logic [3:0]        rise_s;
    logic              press_s;
    logic              sym_valid_s;
    logic [1:0]        sym_code_s;
    logic              match_s;
    logic              last_s;
    logic [EW-1:0]     entry_cnt_r, entry_cnt_s;
    logic [FW-1:0]     fail_cnt_r, fail_cnt_s;
    logic              mismatch_r, mismatch_s;
    logic [TW-1:0]     timer_r, timer_s;
    logic              unlocked_r, error_r, locked_r, prog_busy_r;
    logic [2*SEQ_LEN-1:0] pwd_s;

`ifdef PWD_PROG_EN
    logic [2*SEQ_LEN-1:0] pwd_r, pwd_next_s;
    logic [2*SEQ_LEN-1:0] shadow_r, shadow_s;
    assign pwd_s = pwd_r;
`else
    logic unused_prog_s;
    assign unused_prog_s = prog;
    assign pwd_s         = PASSWORD;
`endif

    assign rise_s                    = {R, L, D, T} & ~hist_r;
    assign press_s                   = |rise_s;
    assign {sym_valid_s, sym_code_s} = decode_sym(rise_s);
    assign match_s = sym_valid_s && (sym_code_s == get_slot(pwd_s, entry_cnt_r));
    assign last_s  = (entry_cnt_r == LAST_IDX);

    // Next-state and datapath update for the authentication FSM.
    always_comb begin
        state_s     = state_r;
        entry_cnt_s = entry_cnt_r;
        fail_cnt_s  = fail_cnt_r;
        mismatch_s  = mismatch_r;
        timer_s     = timer_r;
`ifdef PWD_PROG_EN
        pwd_next_s  = pwd_r;
        shadow_s    = shadow_r;
`endif
        case (state_r)
            ST_ENTRY: begin
                if (press_s) begin
                    if (last_s) begin
                        entry_cnt_s = '0;
                        mismatch_s  = 1'b0;
                        if (!mismatch_r && match_s) begin
                            state_s    = ST_UNLOCKED;
                            fail_cnt_s = '0;
                            timer_s    = T_UNLOCK;
                        end else begin
                            state_s = ST_FAIL;
                            if (fail_cnt_r < FAIL_LIMIT) begin
                                fail_cnt_s = fail_cnt_r + FW'(1);
                            end else begin
                                fail_cnt_s = fail_cnt_r;
                            end
                        end
                    end else begin
                        entry_cnt_s = entry_cnt_r + EW'(1);
                        mismatch_s  = mismatch_r | ~match_s;
                    end
                end else begin
                    state_s = ST_ENTRY;
                end
            end
            ST_UNLOCKED: begin
`ifdef PWD_PROG_EN
                if (prog) begin
                    state_s     = ST_PROGRAM;
                    timer_s     = T_UNLOCK;
                    entry_cnt_s = '0;
                    shadow_s    = pwd_r;
                end else
`endif
                if (timer_r == T_ONE) begin
                    state_s = ST_ENTRY;
                end else begin
                    timer_s = timer_r - T_ONE;
                end
            end
            ST_FAIL: begin
                if (fail_cnt_r == FAIL_LIMIT) begin
                    state_s = ST_LOCKOUT;
                    timer_s = T_LOCK;
                end else begin
                    state_s = ST_ENTRY;
                end
            end
            ST_LOCKOUT: begin
                if (timer_r == T_ONE) begin
                    state_s    = ST_ENTRY;
                    fail_cnt_s = '0;
                end else begin
                    timer_s = timer_r - T_ONE;
                end
            end
`ifdef PWD_PROG_EN
            ST_PROGRAM: begin
                if (sym_valid_s && last_s) begin
                    pwd_next_s  = set_slot(shadow_r, entry_cnt_r, sym_code_s);
                    entry_cnt_s = '0;
                    state_s     = ST_ENTRY;
                end else if (timer_r == T_ONE) begin
                    entry_cnt_s = '0;
                    state_s     = ST_ENTRY;
                end else begin
                    timer_s = timer_r - T_ONE;
                    if (sym_valid_s) begin
                        shadow_s    = set_slot(shadow_r, entry_cnt_r, sym_code_s);
                        entry_cnt_s = entry_cnt_r + EW'(1);
                    end else begin
                        entry_cnt_s = entry_cnt_r;
                    end
                end
            end
`endif
            default: begin
                state_s     = ST_ENTRY;
                entry_cnt_s = '0;
                mismatch_s  = 1'b0;
            end
        endcase
    end

`ifdef PWD_PROG_EN
    // Overwrite password slot idx with sym.
    function automatic logic [2*SEQ_LEN-1:0] set_slot(input logic [2*SEQ_LEN-1:0] pw,
                                                      input logic [EW-1:0] idx,
                                                      input logic [1:0] sym);
        logic [2*SEQ_LEN-1:0] r;
        r = pw;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (idx == EW'(i)) r[2*i +: 2] = sym;
        end
        return r;
    endfunction

    // Password storage: reset value, replaced only by a completed write.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwd_r    <= PASSWORD;
            shadow_r <= PASSWORD;
        end else begin
            pwd_r    <= pwd_next_s;
            shadow_r <= shadow_s;
        end
    end
`endif

    // State, counters, button history and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_ENTRY;
            hist_r      <= 4'b1111;
            entry_cnt_r <= '0;
            fail_cnt_r  <= '0;
            mismatch_r  <= 1'b0;
            timer_r     <= '0;
            unlocked_r  <= 1'b0;
            error_r     <= 1'b0;
            locked_r    <= 1'b0;
            prog_busy_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            hist_r      <= {R, L, D, T};
            entry_cnt_r <= entry_cnt_s;
            fail_cnt_r  <= fail_cnt_s;
            mismatch_r  <= mismatch_s;
            timer_r     <= timer_s;
            unlocked_r  <= (state_s == ST_UNLOCKED);
            error_r     <= (state_s == ST_FAIL);
            locked_r    <= (state_s == ST_LOCKOUT);
            prog_busy_r <= (state_s == ST_PROGRAM);
        end
    end

    assign unlocked  = unlocked_r;
    assign error     = error_r;
    assign locked    = locked_r;
    assign prog_busy = prog_busy_r;
    assign entry_cnt = entry_cnt_r;
    assign fail_cnt  = fail_cnt_r;

endmodule
